// File: rtl/alu_rs_if.sv
// ---------------------------------------------------------------------------
// alu_rs_if : bus bundle between the ALU reservation station and its
//             neighbours (dispatch stage, common data bus, ALU issue port).
//
//   master : the environment side. It drives dispatch and CDB, and it sees
//            disp_ready, the issued op and the occupancy.
//   slave  : the reservation station side.
//
//   Dispatch : disp_valid/disp_ready, disp_op, disp_vj/qj_valid/qj,
//              disp_vk/qk_valid/qk, disp_dest
//   CDB      : cdb_valid, cdb_tag, cdb_value
//   Issue    : alu_valid, alu_op, alu_op1, alu_op2, alu_dest
//   Status   : rs_count
// ---------------------------------------------------------------------------
interface alu_rs_if #(
  parameter int ENTRIES = 8,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 5
);
  localparam int CW = $clog2(ENTRIES) + 1;

  logic             disp_valid;
  logic             disp_ready;
  logic [OP_W-1:0]  disp_op;
  logic [31:0]      disp_vj;
  logic             disp_qj_valid;
  logic [TAG_W-1:0] disp_qj;
  logic [31:0]      disp_vk;
  logic             disp_qk_valid;
  logic [TAG_W-1:0] disp_qk;
  logic [TAG_W-1:0] disp_dest;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;

  logic             alu_valid;
  logic [OP_W-1:0]  alu_op;
  logic [31:0]      alu_op1;
  logic [31:0]      alu_op2;
  logic [TAG_W-1:0] alu_dest;

  logic [CW-1:0]    rs_count;

  modport master (
    output disp_valid, disp_op, disp_vj, disp_qj_valid, disp_qj,
           disp_vk, disp_qk_valid, disp_qk, disp_dest,
           cdb_valid, cdb_tag, cdb_value,
    input  disp_ready, alu_valid, alu_op, alu_op1, alu_op2, alu_dest, rs_count
  );

  modport slave (
    input  disp_valid, disp_op, disp_vj, disp_qj_valid, disp_qj,
           disp_vk, disp_qk_valid, disp_qk, disp_dest,
           cdb_valid, cdb_tag, cdb_value,
    output disp_ready, alu_valid, alu_op, alu_op1, alu_op2, alu_dest, rs_count
  );
endinterface

// File: rtl/alu_rs.sv
// ---------------------------------------------------------------------------
// alu_rs : reservation station in front of the combinational ALU.
//
// This block buffers dispatched ALU and branch micro-ops. It snoops the CDB
// to capture operands that are still pending. Each cycle it issues the
// lowest-index slot whose two operands are both ready to registered alu_*
// outputs. The ALU takes one op per cycle, so issue is never back-pressured.
//
// Ports
//   clk_in   : system clock
//   rst_in   : asynchronous active-low reset
//   rdy_in   : global ready; when low, all state is frozen and inputs ignored
//   flush_in : synchronous mispredict flush; empties the station
//   bus      : alu_rs_if.slave (dispatch, CDB, issue and occupancy)
// ---------------------------------------------------------------------------
module alu_rs #(
  parameter int ENTRIES = 8,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 5
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     flush_in,
  alu_rs_if.slave  bus
);
  localparam int IW = $clog2(ENTRIES);
  localparam int CW = IW + 1;

  // Slot control state (reset)
  logic [ENTRIES-1:0] r_valid;
  logic [ENTRIES-1:0] r_qj_v;
  logic [ENTRIES-1:0] r_qk_v;
  logic [CW-1:0]      r_count;

  // Slot payload (not reset; only meaningful while r_valid is set)
  logic [OP_W-1:0]    r_op   [ENTRIES];
  logic [31:0]        r_vj   [ENTRIES];
  logic [31:0]        r_vk   [ENTRIES];
  logic [TAG_W-1:0]   r_qj   [ENTRIES];
  logic [TAG_W-1:0]   r_qk   [ENTRIES];
  logic [TAG_W-1:0]   r_dest [ENTRIES];

  // Issue register toward the ALU
  logic               r_alu_valid;
  logic [OP_W-1:0]    r_alu_op;
  logic [31:0]        r_alu_op1;
  logic [31:0]        r_alu_op2;
  logic [TAG_W-1:0]   r_alu_dest;

  logic               w_update;
  logic               w_disp_ready;
  logic               w_disp_fire;
  logic               w_fwd_j;
  logic               w_fwd_k;
  logic [IW-1:0]      w_free_idx;
  logic               w_iss_found;
  logic [IW-1:0]      w_iss_idx;
  logic [ENTRIES-1:0] w_wake_j;
  logic [ENTRIES-1:0] w_wake_k;

  assign w_update     = rdy_in & ~flush_in;
  // Only the registered occupancy drives this signal. A slot freed by this
  // cycle's issue is not offered until the next cycle.
  assign w_disp_ready = (r_count != CW'(ENTRIES));
  assign w_disp_fire  = bus.disp_valid & w_disp_ready;

  // A pending operand can be forwarded from the CDB in the dispatch cycle.
  assign w_fwd_j = bus.disp_qj_valid & bus.cdb_valid & (bus.cdb_tag == bus.disp_qj);
  assign w_fwd_k = bus.disp_qk_valid & bus.cdb_valid & (bus.cdb_tag == bus.disp_qk);

  // Select the lowest free slot and the lowest eligible slot. The loops run
  // downward so that the lowest match is the one that remains.
  always_comb begin
    w_free_idx  = '0;
    w_iss_found = 1'b0;
    w_iss_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_idx = IW'(i);
      end
      if (r_valid[i] && !r_qj_v[i] && !r_qk_v[i]) begin
        w_iss_found = 1'b1;
        w_iss_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    w_wake_j = '0;
    w_wake_k = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_wake_j[i] = r_valid[i] & r_qj_v[i] & bus.cdb_valid & (r_qj[i] == bus.cdb_tag);
      w_wake_k[i] = r_valid[i] & r_qk_v[i] & bus.cdb_valid & (r_qk[i] == bus.cdb_tag);
    end
  end

  // Stage boundary: slot state and issue register update on the clock edge
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_valid     <= '0;
      r_qj_v      <= '0;
      r_qk_v      <= '0;
      r_count     <= '0;
      r_alu_valid <= 1'b0;
      r_alu_op    <= '0;
      r_alu_op1   <= '0;
      r_alu_op2   <= '0;
      r_alu_dest  <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_valid     <= '0;
        r_count     <= '0;
        r_alu_valid <= 1'b0;
      end else begin
        r_alu_valid <= w_iss_found;
        if (w_iss_found) begin
          r_alu_op           <= r_op[w_iss_idx];
          r_alu_op1          <= r_vj[w_iss_idx];
          r_alu_op2          <= r_vk[w_iss_idx];
          r_alu_dest         <= r_dest[w_iss_idx];
          r_valid[w_iss_idx] <= 1'b0;
        end
        r_qj_v <= r_qj_v & ~w_wake_j;
        r_qk_v <= r_qk_v & ~w_wake_k;
        // The dispatch slot is currently invalid, so it cannot be the issue
        // slot or a wakeup target.
        if (w_disp_fire) begin
          r_valid[w_free_idx] <= 1'b1;
          r_qj_v[w_free_idx]  <= bus.disp_qj_valid & ~w_fwd_j;
          r_qk_v[w_free_idx]  <= bus.disp_qk_valid & ~w_fwd_k;
        end
        r_count <= r_count + CW'(w_disp_fire) - CW'(w_iss_found);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_update) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_wake_j[i]) r_vj[i] <= bus.cdb_value;
        if (w_wake_k[i]) r_vk[i] <= bus.cdb_value;
      end
      if (w_disp_fire) begin
        r_op[w_free_idx]   <= bus.disp_op;
        r_vj[w_free_idx]   <= w_fwd_j ? bus.cdb_value : bus.disp_vj;
        r_vk[w_free_idx]   <= w_fwd_k ? bus.cdb_value : bus.disp_vk;
        r_qj[w_free_idx]   <= bus.disp_qj;
        r_qk[w_free_idx]   <= bus.disp_qk;
        r_dest[w_free_idx] <= bus.disp_dest;
      end
    end
  end

  assign bus.disp_ready = w_disp_ready;
  assign bus.alu_valid  = r_alu_valid;
  assign bus.alu_op     = r_alu_op;
  assign bus.alu_op1    = r_alu_op1;
  assign bus.alu_op2    = r_alu_op2;
  assign bus.alu_dest   = r_alu_dest;
  assign bus.rs_count   = r_count;

endmodule

// File: tb/tb_alu_rs.sv
// ---------------------------------------------------------------------------
// tb_alu_rs : self-checking bench for alu_rs. A slot-level reference model
// steps once per clock. Directed scenarios are run first, then randomized
// traffic.
// ---------------------------------------------------------------------------
module tb_alu_rs;
  localparam int ENTRIES = 8;
  localparam int TAG_W   = 4;
  localparam int OP_W    = 5;
  localparam logic [OP_W-1:0] OP_ADD = 5'd1;
  localparam logic [OP_W-1:0] OP_SUB = 5'd2;

  logic clk;
  logic rst_n;
  logic rdy;
  logic flush;

  int n_checks = 0;
  int n_errors = 0;

  alu_rs_if #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .OP_W(OP_W)) bus ();

  alu_rs #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
    .clk_in   (clk),
    .rst_in   (rst_n),
    .rdy_in   (rdy),
    .flush_in (flush),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    bit               v;
    logic [OP_W-1:0]  op;
    logic [31:0]      vj;
    logic [31:0]      vk;
    bit               qjv;
    bit               qkv;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [TAG_W-1:0] dest;
  } slot_t;

  slot_t            m_slot [ENTRIES];
  int               m_count;
  bit               m_av;
  logic [OP_W-1:0]  m_aop;
  logic [31:0]      m_a1;
  logic [31:0]      m_a2;
  logic [TAG_W-1:0] m_ad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_slot[i].v = 1'b0;
    m_count = 0;
    m_av = 1'b0; m_aop = '0; m_a1 = '0; m_a2 = '0; m_ad = '0;
  endtask

  // One clock of behaviour, computed from the current inputs and the
  // state before the edge.
  task automatic model_step();
    slot_t pre [ENTRIES];
    int    iss;
    int    fr;
    bit    fire;
    if (!rdy) return;
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) m_slot[i].v = 1'b0;
      m_count = 0;
      m_av = 1'b0;
      return;
    end
    pre = m_slot;
    iss = -1;
    for (int i = 0; i < ENTRIES; i++)
      if (iss < 0 && pre[i].v && !pre[i].qjv && !pre[i].qkv) iss = i;
    if (iss >= 0) begin
      m_av = 1'b1;
      m_aop = pre[iss].op; m_a1 = pre[iss].vj; m_a2 = pre[iss].vk; m_ad = pre[iss].dest;
      m_slot[iss].v = 1'b0;
    end else begin
      m_av = 1'b0;
    end
    if (bus.cdb_valid) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (pre[i].v && pre[i].qjv && pre[i].qj == bus.cdb_tag) begin
          m_slot[i].qjv = 1'b0; m_slot[i].vj = bus.cdb_value;
        end
        if (pre[i].v && pre[i].qkv && pre[i].qk == bus.cdb_tag) begin
          m_slot[i].qkv = 1'b0; m_slot[i].vk = bus.cdb_value;
        end
      end
    end
    fire = bus.disp_valid && (m_count != ENTRIES);
    if (fire) begin
      fr = -1;
      for (int i = 0; i < ENTRIES; i++) if (fr < 0 && !pre[i].v) fr = i;
      m_slot[fr].v    = 1'b1;
      m_slot[fr].op   = bus.disp_op;
      m_slot[fr].qj   = bus.disp_qj;
      m_slot[fr].qk   = bus.disp_qk;
      m_slot[fr].dest = bus.disp_dest;
      if (bus.disp_qj_valid && bus.cdb_valid && bus.cdb_tag == bus.disp_qj) begin
        m_slot[fr].qjv = 1'b0; m_slot[fr].vj = bus.cdb_value;
      end else begin
        m_slot[fr].qjv = bus.disp_qj_valid; m_slot[fr].vj = bus.disp_vj;
      end
      if (bus.disp_qk_valid && bus.cdb_valid && bus.cdb_tag == bus.disp_qk) begin
        m_slot[fr].qkv = 1'b0; m_slot[fr].vk = bus.cdb_value;
      end else begin
        m_slot[fr].qkv = bus.disp_qk_valid; m_slot[fr].vk = bus.disp_vk;
      end
    end
    m_count = m_count + (fire ? 1 : 0) - (iss >= 0 ? 1 : 0);
  endtask

  task automatic cmp_model();
    chk("alu_valid",  64'(bus.alu_valid),  64'(m_av));
    chk("alu_op",     64'(bus.alu_op),     64'(m_aop));
    chk("alu_op1",    64'(bus.alu_op1),    64'(m_a1));
    chk("alu_op2",    64'(bus.alu_op2),    64'(m_a2));
    chk("alu_dest",   64'(bus.alu_dest),   64'(m_ad));
    chk("rs_count",   64'(bus.rs_count),   64'(m_count));
    chk("disp_ready", 64'(bus.disp_ready), 64'(m_count != ENTRIES));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0; bus.disp_op = '0; bus.disp_vj = '0; bus.disp_vk = '0;
    bus.disp_qj_valid = 1'b0; bus.disp_qj = '0; bus.disp_qk_valid = 1'b0;
    bus.disp_qk = '0; bus.disp_dest = '0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_value = '0;
    flush = 1'b0; rdy = 1'b1;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [31:0] vj, input bit qjv,
                      input logic [TAG_W-1:0] qj, input logic [31:0] vk, input bit qkv,
                      input logic [TAG_W-1:0] qk, input logic [TAG_W-1:0] dest);
    bus.disp_valid = 1'b1; bus.disp_op = op;
    bus.disp_vj = vj; bus.disp_qj_valid = qjv; bus.disp_qj = qj;
    bus.disp_vk = vk; bus.disp_qk_valid = qkv; bus.disp_qk = qk;
    bus.disp_dest = dest;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] tag, input logic [31:0] val);
    bus.cdb_valid = 1'b1; bus.cdb_tag = tag; bus.cdb_value = val;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_valid", 64'(bus.alu_valid), 64'd0);
    chk("rst_rs_count",  64'(bus.rs_count),  64'd0);
    chk("rst_alu_op1",   64'(bus.alu_op1),   64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_disp_ready", 64'(bus.disp_ready), 64'd1);

    // Ready ADD issues two edges after it is presented
    disp(OP_ADD, 32'd5, 0, 4'd0, 32'd7, 0, 4'd0, 4'd3);
    tick();
    chk("t1_not_yet", 64'(bus.alu_valid), 64'd0);
    idle();
    tick();
    chk("t1_valid", 64'(bus.alu_valid), 64'd1);
    chk("t1_op",    64'(bus.alu_op),    64'(OP_ADD));
    chk("t1_op1",   64'(bus.alu_op1),   64'd5);
    chk("t1_op2",   64'(bus.alu_op2),   64'd7);
    chk("t1_dest",  64'(bus.alu_dest),  64'd3);
    chk("t1_count", 64'(bus.rs_count),  64'd0);

    // SUB waits on tag 2 and wakes up on the CDB
    disp(OP_SUB, 32'd0, 1, 4'd2, 32'd1, 0, 4'd0, 4'd4);
    tick();
    idle();
    tick();
    cdb(4'd2, 32'd10);
    tick();
    chk("t2_wait", 64'(bus.alu_valid), 64'd0);
    idle();
    tick();
    chk("t2_valid", 64'(bus.alu_valid), 64'd1);
    chk("t2_op1",   64'(bus.alu_op1),   64'd10);
    chk("t2_op2",   64'(bus.alu_op2),   64'd1);

    // Forwarding from the CDB in the dispatch cycle
    disp(OP_ADD, 32'd3, 0, 4'd0, 32'd0, 1, 4'd6, 4'd5);
    cdb(4'd6, 32'hFFFF_FFFF);
    tick();
    idle();
    tick();
    chk("t3_valid", 64'(bus.alu_valid), 64'd1);
    chk("t3_op2",   64'(bus.alu_op2),   64'hFFFF_FFFF);
    chk("t3_dest",  64'(bus.alu_dest),  64'd5);

    // Fill every slot, all waiting on tag 9
    for (int i = 0; i < ENTRIES; i++) begin
      disp(OP_ADD, 32'(i), 1, 4'd9, 32'(100 + i), 0, 4'd0, 4'(i));
      tick();
    end
    chk("t4_full_ready", 64'(bus.disp_ready), 64'd0);
    chk("t4_full_count", 64'(bus.rs_count),   64'd8);
    disp(OP_SUB, 32'd1, 0, 4'd0, 32'd1, 0, 4'd0, 4'd15);
    tick();
    chk("t4_extra_ignored", 64'(bus.rs_count), 64'd8);
    idle();
    cdb(4'd9, 32'h99);
    tick();
    idle();
    for (int i = 0; i < ENTRIES; i++) begin
      tick();
      chk("t4_order_valid", 64'(bus.alu_valid), 64'd1);
      chk("t4_order_dest",  64'(bus.alu_dest),  64'(i));
      chk("t4_order_op1",   64'(bus.alu_op1),   64'h99);
      if (i == 0) chk("t4_ready_after_issue", 64'(bus.disp_ready), 64'd1);
    end
    tick();
    chk("t4_drained", 64'(bus.alu_valid), 64'd0);

    // Flush with a simultaneous dispatch
    for (int i = 0; i < 4; i++) begin
      disp(OP_ADD, 32'd0, 1, 4'd11, 32'd0, 0, 4'd0, 4'(8 + i));
      tick();
    end
    idle();
    flush = 1'b1;
    disp(OP_ADD, 32'd1, 0, 4'd0, 32'd2, 0, 4'd0, 4'd12);
    tick();
    chk("t5_count", 64'(bus.rs_count),  64'd0);
    chk("t5_valid", 64'(bus.alu_valid), 64'd0);
    idle();
    cdb(4'd11, 32'd1);
    tick();
    idle();
    tick();
    chk("t5_absent", 64'(bus.alu_valid), 64'd0);

    // Freeze while rdy is low; the broadcast during the freeze is lost
    disp(OP_SUB, 32'd0, 1, 4'd5, 32'd2, 0, 4'd0, 4'd2);
    tick();
    disp(OP_ADD, 32'd21, 0, 4'd0, 32'd22, 0, 4'd0, 4'd1);
    tick();
    idle();
    rdy = 1'b0;
    cdb(4'd5, 32'd77);
    repeat (3) begin
      tick();
      chk("t6_frozen_count", 64'(bus.rs_count),  64'd2);
      chk("t6_frozen_valid", 64'(bus.alu_valid), 64'd0);
    end
    idle();
    tick();
    chk("t6_issue_valid", 64'(bus.alu_valid), 64'd1);
    chk("t6_issue_dest",  64'(bus.alu_dest),  64'd1);
    chk("t6_issue_op1",   64'(bus.alu_op1),   64'd21);
    // Reset asserted between clock edges takes effect at once
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_valid", 64'(bus.alu_valid), 64'd0);
    chk("t6_async_op1",   64'(bus.alu_op1),   64'd0);
    chk("t6_async_dest",  64'(bus.alu_dest),  64'd0);
    chk("t6_async_count", 64'(bus.rs_count),  64'd0);
    rst_n = 1'b1;
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 49) == 0);
      bus.disp_valid    = $urandom_range(0, 1) == 1;
      bus.disp_op       = OP_W'($urandom);
      bus.disp_vj       = $urandom;
      bus.disp_vk       = $urandom;
      bus.disp_qj_valid = $urandom_range(0, 1) == 1;
      bus.disp_qk_valid = $urandom_range(0, 2) == 0;
      bus.disp_qj       = TAG_W'($urandom);
      bus.disp_qk       = TAG_W'($urandom);
      bus.disp_dest     = TAG_W'($urandom);
      bus.cdb_valid     = $urandom_range(0, 1) == 1;
      bus.cdb_tag       = TAG_W'($urandom);
      bus.cdb_value     = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station directly upstream of the ALU in the out-of-order core.
- Buffers dispatched ALU/branch micro-ops and snoops the common data bus (CDB) for pending operands.
- Each cycle, issues at most one operand-ready entry to the combinational ALU as {alu_op, op1, op2} plus its ROB destination tag.
- The ALU accepts one op per cycle, so there is no issue backpressure.

Parameters:
- ENTRIES, 8, number of station slots (power of two, 2..16).
- TAG_W, 4, ROB tag width.
- OP_W, 5, ALU opcode width; matches the ALU alu_op encoding.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous active-low reset.
- rdy_in  in  1  global ready; low freezes all state.
- flush_in  in  1  mispredict flush; synchronous.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  a free slot exists.
- disp_op  in  OP_W  ALU opcode.
- disp_vj  in  32  operand 1 value (valid when disp_qj_valid=0).
- disp_qj_valid  in  1  operand 1 pending.
- disp_qj  in  TAG_W  producer tag of operand 1.
- disp_vk  in  32  operand 2 value.
- disp_qk_valid  in  1  operand 2 pending.
- disp_qk  in  TAG_W  producer tag of operand 2.
- disp_dest  in  TAG_W  ROB tag of the result.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_value  in  32  broadcast value.
- alu_valid  out  1  issued op valid.
- alu_op  out  OP_W  issued opcode.
- alu_op1  out  32  issued operand 1.
- alu_op2  out  32  issued operand 2.
- alu_dest  out  TAG_W  issued ROB tag.
- rs_count  out  $clog2(ENTRIES)+1  occupied slots.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - All slots invalid; rs_count=0.
  - alu_valid=0; alu_op, alu_op1, alu_op2, alu_dest = 0.
  - disp_ready=1 once reset is released.
- Priority on each rising edge: rdy_in low > flush_in > normal operation.
- rdy_in=0: no state or output register changes. Dispatch and CDB inputs that cycle are ignored; upstream is paused as well.
- flush_in=1 (rdy_in=1):
  - All slots invalid, rs_count=0, alu_valid=0 on the next cycle.
  - Dispatch and CDB inputs that cycle are dropped.
- disp_ready = (rs_count != ENTRIES), combinational from registered occupancy only.
  - A slot freed by issue in the same cycle is not visible to disp_ready.
- Dispatch (disp_valid & disp_ready):
  - Writes the lowest-index invalid slot.
  - Forwarding: if an operand is pending and cdb_valid & cdb_tag == its tag in the same cycle, the slot stores cdb_value with the operand marked ready.
  - A newly dispatched slot is not issue-eligible until the following cycle.
  - disp_valid with disp_ready=0 is ignored; the dispatcher must hold the request.
- Wakeup: every valid slot with a pending operand whose tag equals cdb_tag while cdb_valid=1 captures cdb_value and clears the pending flag. Both operands may wake on the same broadcast.
  - Eligibility uses registered ready flags, so a slot woken in cycle N can issue no earlier than cycle N+1.
- Issue:
  - Selects the lowest-index valid slot with both operands ready.
  - On the edge, registers the slot's op, values and dest into the alu_* outputs, sets alu_valid=1 and frees the slot.
  - If no slot is eligible, alu_valid=0 next cycle; the alu_* data registers hold their previous values.
  - Latency: an eligible slot appears on the alu_* outputs one cycle after it is selected.
- Occupancy:
  - rs_count_next = rs_count + dispatch_fire - issue_fire.
  - Simultaneous dispatch and issue leaves the count unchanged.
  - Never exceeds ENTRIES and never underflows.
- Tags are unique in flight; a CDB tag matching no slot has no effect.

Test Plan:
- Reset, then dispatch op=ADD, vj=5, vk=7, both ready, dest=3 -> next cycle alu_valid=1, alu_op=ADD, alu_op1=5, alu_op2=7, alu_dest=3; rs_count returns to 0.
- Dispatch SUB with qj=2 pending and vk=1; CDB tag=2, value=10 two cycles later -> issue one cycle after the broadcast with alu_op1=10, alu_op2=1.
- Dispatch with qk=6 pending while the same cycle carries cdb_valid, tag=6, value=0xFFFF_FFFF -> forwarded; issues next cycle with alu_op2=0xFFFF_FFFF.
- Fill all 8 slots, each waiting on tag 9 -> disp_ready=0, rs_count=8, extra dispatch ignored. Broadcast tag 9 -> slots issue in index order 0..7 on consecutive cycles; disp_ready=1 after the first issue edge.
- Four pending slots, flush_in=1 with a simultaneous dispatch -> next cycle rs_count=0, alu_valid=0, dispatched op absent.
- Hold rdy_in=0 for 3 cycles with a ready slot and a CDB broadcast present -> outputs and rs_count frozen, broadcast lost. Assert rst_in low mid-operation -> outputs zero immediately, without waiting for a clock edge.
